stream_rr_arbiter: RTL and testbench

Round-robin arbiter that shares one FWFT stream channel among NUM_PORTS producer streams. Each producer presents a first-word-fall-through read interface: empty_n, read and dout. The arbiter pops words from the granted producer and writes them, tagged with the source index, into a single downstream FIFO write interface, such as a relay_station input. Grants are held for bursts of up to MAX_BURST words to amortise switching; one registered output stage keeps all downstream paths register-driven.

---
 rtl/stream_rr_arbiter.sv | 123 ++++++++++++
 tb/tb_stream_rr_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_rr_arbiter.sv
// Round-robin arbiter merging NUM_PORTS FWFT producer streams into one
// tagged FIFO write stream, with burst-limited grants and a registered output.
module stream_rr_arbiter #(
    parameter int NUM_PORTS  = 4,
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 2,
    parameter int MAX_BURST  = 8
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic [NUM_PORTS-1:0]            port_enable,
    input  logic [NUM_PORTS-1:0]            in_empty_n,
    output logic [NUM_PORTS-1:0]            in_read,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] in_dout,
    input  logic                            out_full_n,
    output logic                            out_write,
    output logic [TAG_WIDTH+DATA_WIDTH-1:0] out_din,
    output logic                            grant_valid,
    output logic [TAG_WIDTH-1:0]            grant_id
);
    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int CW = $clog2(MAX_BURST + 1);
    localparam int OW = TAG_WIDTH + DATA_WIDTH;
    localparam logic [CW-1:0] LAST = CW'(MAX_BURST - 1);
    localparam logic [PW-1:0] TOP  = PW'(NUM_PORTS - 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t                state, state_nxt;
    logic [PW-1:0]         ptr, ptr_nxt;
    logic [PW-1:0]         g, g_nxt, g_inc, pick;
    logic [CW-1:0]         cnt, cnt_nxt;
    logic                  out_valid, ov_nxt;
    logic [OW-1:0]         out_data, od_nxt;
    logic [NUM_PORTS-1:0]  req, g_mask, rot;
    logic [DATA_WIDTH-1:0] g_data;
    logic                  req_g, can_load, xfer, found;

    assign req      = in_empty_n & port_enable;
    assign g_mask   = NUM_PORTS'(1) << g;
    assign req_g    = |(req & g_mask);
    assign can_load = !out_valid || out_full_n;
    assign xfer     = (state == GRANT) && req_g && can_load;
    assign g_inc    = (g == TOP) ? '0 : g + 1'b1;
    assign g_data   = DATA_WIDTH'(in_dout >> (DATA_WIDTH * int'(g)));
    assign rot      = NUM_PORTS'({req, req} >> ptr);

    assign in_read     = xfer ? g_mask : '0;
    assign out_write   = out_valid;
    assign out_din     = out_data;
    assign grant_valid = (state == GRANT);
    assign grant_id    = grant_valid ? TAG_WIDTH'(g) : '0;

    // first requesting port at or after ptr, wrapping around
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (!found && rot[i]) begin
                found = 1'b1;
                pick  = PW'((int'(ptr) + i) % NUM_PORTS);
            end
        end
    end

    // grant FSM next state, burst counting and output-register loading
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        g_nxt     = g;
        cnt_nxt   = cnt;
        ov_nxt    = out_valid;
        od_nxt    = out_data;
        unique case (state)
            IDLE: begin
                if (|req) begin
                    state_nxt = GRANT;
                    g_nxt     = pick;
                    cnt_nxt   = '0;
                end
            end
            GRANT: begin
                if (!req_g) begin
                    state_nxt = IDLE;
                    ptr_nxt   = g_inc;
                end else if (xfer) begin
                    cnt_nxt = cnt + 1'b1;
                    if (cnt == LAST) begin
                        state_nxt = IDLE;
                        ptr_nxt   = g_inc;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (xfer) begin
            ov_nxt = 1'b1;
            od_nxt = {TAG_WIDTH'(g), g_data};
        end else if (out_valid && out_full_n) begin
            ov_nxt = 1'b0;
        end
    end

    // state registers; reset discards any word held in the output stage
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            ptr       <= '0;
            g         <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            g         <= g_nxt;
            cnt       <= cnt_nxt;
            out_valid <= ov_nxt;
            out_data  <= od_nxt;
        end
    end

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Bench for stream_rr_arbiter: a 4-port/burst-8 instance driven by
// queue-backed sources, plus free-running burst-2 and single-port instances.
module tb_stream_rr_arbiter;

    typedef struct {
        logic [3:0] en;
        logic       full_n;
        logic [3:0] rd;
        logic       gv;
        logic [1:0] gid;
        logic       wr;
    } vec_t;

    logic clk = 1'b0;
    logic rst_a, rst_bc;

    logic [3:0]   en_a, emp_a, rd_a;
    logic [127:0] dout_a;
    logic         full_a, wr_a, gv_a;
    logic [33:0]  din_a;
    logic [1:0]   gid_a;

    logic [3:0]   en_b, emp_b, rd_b;
    logic [127:0] dout_b;
    logic         full_b, wr_b, gv_b;
    logic [33:0]  din_b;
    logic [1:0]   gid_b;

    logic [0:0]   en_c, emp_c, rd_c, gid_c;
    logic [31:0]  dout_c;
    logic         full_c, wr_c, gv_c;
    logic [32:0]  din_c;

    logic [31:0] srcq[4][$];
    logic [33:0] expq[$];
    logic [3:0]  rd_a_l, rd_b_l;
    logic [0:0]  rd_c_l;
    int seq_b[4];
    int seq_c;
    int n_vec = 0, n_err = 0, cyc = 0;
    int wb_cnt = 0, wb_last = 0, wc_cnt = 0, wc_last = 0;
    vec_t tbl[6];

    stream_rr_arbiter #(.NUM_PORTS(4), .DATA_WIDTH(32), .TAG_WIDTH(2),
                        .MAX_BURST(8)) u_a (
        .clk(clk), .reset_n(rst_a), .port_enable(en_a),
        .in_empty_n(emp_a), .in_read(rd_a), .in_dout(dout_a),
        .out_full_n(full_a), .out_write(wr_a), .out_din(din_a),
        .grant_valid(gv_a), .grant_id(gid_a));

    stream_rr_arbiter #(.NUM_PORTS(4), .DATA_WIDTH(32), .TAG_WIDTH(2),
                        .MAX_BURST(2)) u_b (
        .clk(clk), .reset_n(rst_bc), .port_enable(en_b),
        .in_empty_n(emp_b), .in_read(rd_b), .in_dout(dout_b),
        .out_full_n(full_b), .out_write(wr_b), .out_din(din_b),
        .grant_valid(gv_b), .grant_id(gid_b));

    stream_rr_arbiter #(.NUM_PORTS(1), .DATA_WIDTH(32), .TAG_WIDTH(1),
                        .MAX_BURST(1)) u_c (
        .clk(clk), .reset_n(rst_bc), .port_enable(en_c),
        .in_empty_n(emp_c), .in_read(rd_c), .in_dout(dout_c),
        .out_full_n(full_c), .out_write(wr_c), .out_din(din_c),
        .grant_valid(gv_c), .grant_id(gid_c));

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, run did not finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    task automatic refresh();
        for (int p = 0; p < 4; p++) begin
            emp_a[p] = (srcq[p].size() > 0);
            dout_a[p*32 +: 32] = (srcq[p].size() > 0) ? srcq[p][0] : 32'h0;
            dout_b[p*32 +: 32] = {8'(p), 24'(seq_b[p])};
        end
        dout_c = 32'(seq_c);
    endtask

    task automatic load(input int p, input logic [31:0] w, input bit exp);
        srcq[p].push_back(w);
        if (exp) expq.push_back({2'(p), w});
        refresh();
    endtask

    task automatic settle();
        int t, k;
        @(negedge clk);
        cyc++;
        rd_a_l = rd_a;
        rd_b_l = rd_b;
        rd_c_l = rd_c;
        if (wr_a && full_a) begin
            if (expq.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL a_extra_write: got %0h expected none", din_a);
            end else begin
                check("a_din", din_a, expq.pop_front());
            end
        end
        if (wr_b) begin
            t = (wb_cnt / 2) % 4;
            k = (wb_cnt / 8) * 2 + wb_cnt % 2;
            check("b_din", din_b, {t[1:0], 8'(t), 24'(k)});
            if (wb_cnt > 0)
                check("b_gap", cyc - wb_last, (wb_cnt % 2 == 1) ? 1 : 2);
            wb_last = cyc;
            wb_cnt++;
        end
        if (wr_c) begin
            check("c_din", din_c, {1'b0, 32'(wc_cnt)});
            if (wc_cnt > 0) check("c_gap", cyc - wc_last, 2);
            wc_last = cyc;
            wc_cnt++;
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
        for (int p = 0; p < 4; p++) begin
            if (rd_a_l[p] && srcq[p].size() > 0) void'(srcq[p].pop_front());
            if (rd_b_l[p]) seq_b[p]++;
        end
        if (rd_c_l[0]) seq_c++;
        refresh();
    endtask

    task automatic drain(input int n);
        repeat (n) begin
            settle();
            adv();
        end
        check("a_sb_left", expq.size(), 0);
    endtask

    initial begin
        logic [33:0] held;
        int pops, p3, clr;
        bit seen, done;

        rst_a = 1'b0;
        rst_bc = 1'b0;
        en_a = 4'hF;
        full_a = 1'b1;
        en_b = 4'hF;
        emp_b = 4'hF;
        full_b = 1'b1;
        en_c = 1'b1;
        emp_c = 1'b1;
        full_c = 1'b1;
        rd_a_l = '0;
        rd_b_l = '0;
        rd_c_l = '0;
        seq_c = 0;
        for (int p = 0; p < 4; p++) seq_b[p] = 0;
        refresh();

        tbl[0] = '{4'hF, 1'b1, 4'h0, 1'b0, 2'd0, 1'b0};
        tbl[1] = '{4'hF, 1'b1, 4'h4, 1'b1, 2'd2, 1'b0};
        tbl[2] = '{4'hF, 1'b1, 4'h4, 1'b1, 2'd2, 1'b1};
        tbl[3] = '{4'hF, 1'b1, 4'h4, 1'b1, 2'd2, 1'b1};
        tbl[4] = '{4'hF, 1'b1, 4'h0, 1'b1, 2'd2, 1'b1};
        tbl[5] = '{4'hF, 1'b1, 4'h0, 1'b0, 2'd0, 1'b0};

        // reset state with data already waiting on port 2
        adv();
        load(2, 32'hA0A0_0001, 1);
        load(2, 32'hB0B0_0002, 1);
        load(2, 32'hC0C0_0003, 1);
        settle();
        check("rst_gv", gv_a, 0);
        check("rst_gid", gid_a, 0);
        check("rst_wr", wr_a, 0);
        check("rst_din", din_a, 0);
        check("rst_rd", rd_a, 0);
        adv();
        rst_a = 1'b1;
        rst_bc = 1'b1;

        // single-port burst, cycle by cycle
        for (int v = 0; v < 6; v++) begin
            en_a = tbl[v].en;
            full_a = tbl[v].full_n;
            settle();
            check($sformatf("v%0d_rd", v), rd_a, tbl[v].rd);
            check($sformatf("v%0d_gv", v), gv_a, tbl[v].gv);
            check($sformatf("v%0d_gid", v), gid_a, tbl[v].gid);
            check($sformatf("v%0d_wr", v), wr_a, tbl[v].wr);
            adv();
        end
        check("tbl_sb_left", expq.size(), 0);

        // pointer now 3: port 3 must beat port 0
        load(3, 32'h3333_0001, 1);
        load(0, 32'h0000_0001, 1);
        settle();
        check("ptr_idle_gv", gv_a, 0);
        adv();
        settle();
        check("ptr_gid", gid_a, 3);
        check("ptr_rd", rd_a, 4'h8);
        adv();
        drain(8);

        // backpressure mid-burst on port 0
        for (int i = 0; i < 10; i++) load(0, 32'hD000_0000 + 32'(i), 1);
        pops = 0;
        seen = 0;
        done = 0;
        held = '0;
        for (int k = 0; k < 60; k++) begin
            full_a = !(k >= 4 && k <= 8);
            settle();
            if (gv_a) seen = 1;
            if (rd_a[0] && !done) pops++;
            if (k == 4) held = din_a;
            if (k >= 4 && k <= 8) begin
                check("bp_rd", rd_a, 0);
                check("bp_gv", gv_a, 1);
                check("bp_gid", gid_a, 0);
                check("bp_wr", wr_a, 1);
                if (k > 4) check("bp_din_hold", din_a, held);
            end
            if (seen && !gv_a && !done) begin
                done = 1;
                check("bp_burst_len", pops, 8);
            end
            adv();
        end
        check("bp_release_seen", done, 1);
        full_a = 1'b1;
        drain(4);

        // disabled port 1 skipped; disabling port 3 ends its burst
        en_a = 4'b1101;
        load(1, 32'h1111_0001, 0);
        load(1, 32'h1111_0002, 0);
        for (int i = 0; i < 6; i++) load(3, 32'hE000_0000 + 32'(i), i < 2);
        p3 = 0;
        clr = -1;
        for (int k = 0; k < 20; k++) begin
            settle();
            check("en_rd1", rd_a[1], 0);
            if (k == 1) check("en_gid", gid_a, 3);
            if (rd_a[3]) p3++;
            if (k == clr) begin
                check("en_off_rd", rd_a, 0);
                check("en_off_gv", gv_a, 1);
            end
            if (clr >= 0 && k == clr + 1) check("en_release", gv_a, 0);
            adv();
            if (p3 == 2 && clr < 0) begin
                en_a[3] = 1'b0;
                clr = k + 1;
            end
        end
        drain(4);

        // asynchronous reset mid-burst, then restart from port 0
        for (int p = 0; p < 4; p++) srcq[p].delete();
        en_a = 4'hF;
        refresh();
        load(2, 32'h2222_0000, 1);
        drain(4);
        for (int i = 0; i < 6; i++) load(2, 32'hF000_0000 + 32'(i), 1);
        seen = 0;
        for (int k = 0; k < 10; k++) begin
            settle();
            if (wr_a) begin
                seen = 1;
                break;
            end
            adv();
        end
        check("rst_wr_seen", seen, 1);
        #2;
        rst_a = 1'b0;
        #1;
        check("arst_wr", wr_a, 0);
        check("arst_rd", rd_a, 0);
        check("arst_gv", gv_a, 0);
        check("arst_gid", gid_a, 0);
        check("arst_din", din_a, 0);
        rd_a_l = '0;
        expq.delete();
        for (int p = 0; p < 4; p++) srcq[p].delete();
        load(1, 32'h1234_0001, 1);
        load(3, 32'h1234_0003, 1);
        adv();
        settle();
        check("arst_hold_gv", gv_a, 0);
        adv();
        rst_a = 1'b1;
        settle();
        check("arst_idle_gv", gv_a, 0);
        adv();
        settle();
        check("arst_ptr0_gid", gid_a, 1);
        adv();
        drain(8);

        check("b_words", wb_cnt >= 24, 1);
        check("c_words", wc_cnt >= 24, 1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
